regfile_wb_queue: RTL and testbench
===================================

Name: regfile_wb_queue

Overview:
Write-back queue that drives the register file write port: reg_write, addr3 and wdata.
- Accepts register write-back requests from two producers, the ALU stage and the load unit, over valid/ready handshakes.
- Buffers requests in a small in-order FIFO and retires one write per cycle to the register file.
- Exposes a forwarding lookup so decode can read values that are queued but not yet written.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2.
CW, 3, width of count; equals clog2(DEPTH+1).

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
alu_valid  input  1  ALU write-back request valid.
alu_ready  output  1  ALU request accepted this cycle when alu_valid and alu_ready are both 1.
alu_addr  input  5  destination register of the ALU request.
alu_data  input  32  write data of the ALU request.
mem_valid  input  1  load-unit write-back request valid.
mem_ready  output  1  load request accepted this cycle when mem_valid and mem_ready are both 1.
mem_addr  input  5  destination register of the load request.
mem_data  input  32  write data of the load request.
reg_write  output  1  register-file write enable.
addr3  output  5  register-file write address.
wdata  output  32  register-file write data.
fwd_addr  input  5  forwarding lookup address.
fwd_hit  output  1  a queued entry targets fwd_addr.
fwd_data  output  32  data of the youngest queued entry targeting fwd_addr.
count  output  CW  number of occupied entries.
empty  output  1  count == 0.

Behaviour:
- Storage: circular buffer of DEPTH entries, each holding addr[4:0] and data[31:0], with a write pointer wp, a read pointer rp and the count. Pointers wrap modulo DEPTH.
- Retire:
  - reg_write = !empty; addr3 and wdata = head entry at rp.
  - All three are driven from registers only; there is no combinational path from any input.
  - Whenever empty == 0, the head pops at every posedge: rp+1, count-1.
  - Outputs are stable for the whole cycle, so the register file's negedge write captures them.
- Ready (computed from the pre-edge count only; does not depend on the same-cycle pop):
  - mem_ready = (count <= DEPTH-1).
  - alu_ready = mem_valid ? (count <= DEPTH-2) : (count <= DEPTH-1).
  - The load unit has priority.
- Enqueue: on a posedge with mem_valid and mem_ready, or alu_valid and alu_ready:
  - If both handshakes fire in the same cycle, the mem entry is written at wp and the alu entry at wp+1. The mem entry is older.
  - A request whose addr is 0 completes its handshake but is discarded: no slot is used and count does not change for it.
- Count update: count_next = count + enq_cnt - pop, where enq_cnt is 0..2.
  - Simultaneous enqueue and pop are legal, including at full, where pop frees no same-cycle slot.
  - count never exceeds DEPTH.
- Latency: a request accepted at posedge N appears on reg_write/addr3/wdata after posedge N, is written by the register file at the following negedge, and is popped at posedge N+1, provided the queue was empty.
- Forwarding (combinational over the occupied entries only):
  - fwd_hit = 1 iff fwd_addr != 0 and some occupied entry has addr == fwd_addr.
  - fwd_data = data of the youngest such entry; 0 when fwd_hit = 0.
  - The head entry, written in the current cycle, is included.
  - Entries enqueued at the coming edge are not visible.
- Reset (sync, has priority over every other action, applies mid-operation):
  - wp = rp = count = 0, so reg_write = 0, addr3 = 0, wdata = 0, empty = 1, fwd_hit = 0, fwd_data = 0.
  - alu_ready and mem_ready are forced to 0 while reset = 1.
  - Any in-flight queued writes are dropped and never reach the register file.
- Duplicate addresses in the queue are legal. They retire in order, so the last write wins in the register file.

Test Plan:
- Single write: reset, then one cycle of alu_valid with alu_addr = 5, alu_data = 100 -> next cycle reg_write = 1, addr3 = 5, wdata = 100 for exactly one cycle; then empty = 1 and count = 0.
- Simultaneous requests on an empty queue: mem (addr 3, data 7) and alu (addr 3, data 9) in one cycle -> both ready = 1; retires addr3 = 3/wdata = 7, then addr3 = 3/wdata = 9; fwd_addr = 3 gives fwd_hit = 1 and fwd_data = 9 until the second retire.
- Backpressure: hold alu_valid and mem_valid continuously with distinct nonzero addresses -> count never exceeds 4; alu_ready = 0 whenever count >= 3 and mem_valid = 1; every accepted request retires exactly once, in acceptance order, with mem-before-alu inside each cycle.
- Zero register: alu request with addr 0, data 0xFFFFFFFF -> alu_ready = 1, count stays 0, reg_write stays 0; fwd_addr = 0 gives fwd_hit = 0.
- Wrap-around: stream 10 sequential alu writes (addr 1..10, data = addr*2) with random idle gaps -> retire sequence matches exactly; pointers wrap past DEPTH with no loss.
- Reset mid-operation: fill 3 entries, assert reset for 1 cycle -> during reset both ready = 0; after it count = 0, reg_write = 0, and none of the 3 entries ever appears on addr3.

Source files
------------

// File: rtl/regfile_wb_queue_if.sv
// Bundle of the write-back queue's producer handshakes, register-file write port,
// forwarding lookup and occupancy status.
interface regfile_wb_queue_if #(
  parameter int CW = 3
);
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        reg_write;
  logic [4:0]  addr3;
  logic [31:0] wdata;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [CW-1:0] count;
  logic        empty;

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, fwd_addr,
    output alu_ready, mem_ready, reg_write, addr3, wdata, fwd_hit, fwd_data, count, empty
  );

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, fwd_addr,
    input  alu_ready, mem_ready, reg_write, addr3, wdata, fwd_hit, fwd_data, count, empty
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue feeding the register-file write port from the ALU and
// load unit, with a forwarding lookup over entries not yet retired.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  regfile_wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] LIM_ONE = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LIM_TWO = CW'(DEPTH - 2);

  logic [4:0]    addr_mem_r [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic [PW-1:0] wp_r;
  logic [PW-1:0] rp_r;
  logic [CW-1:0] count_r;

  logic          mem_ready_s;
  logic          alu_ready_s;
  logic          mem_keep_s;
  logic          alu_keep_s;
  logic          pop_s;
  logic [1:0]    enq_cnt_s;
  logic [PW-1:0] alu_slot_s;
  logic          fwd_hit_s;
  logic [31:0]   fwd_data_s;
  logic [PW-1:0] fwd_idx_s;

  // Admission from pre-edge occupancy; the load unit reserves its slot first.
  always_comb begin
    mem_ready_s = 1'b0;
    alu_ready_s = 1'b0;
    if (reset) begin
      mem_ready_s = 1'b0;
      alu_ready_s = 1'b0;
    end else begin
      mem_ready_s = (count_r <= LIM_ONE);
      if (bus.mem_valid) begin
        alu_ready_s = (count_r <= LIM_TWO);
      end else begin
        alu_ready_s = (count_r <= LIM_ONE);
      end
    end
    // Writes to x0 finish their handshake but never occupy a slot.
    mem_keep_s = bus.mem_valid && mem_ready_s && (bus.mem_addr != 5'd0);
    alu_keep_s = bus.alu_valid && alu_ready_s && (bus.alu_addr != 5'd0);
    enq_cnt_s  = {1'b0, mem_keep_s} + {1'b0, alu_keep_s};
    alu_slot_s = wp_r + PW'(mem_keep_s);
    pop_s      = (count_r != {CW{1'b0}});
  end

  // Pointer and occupancy registers; the head retires every non-empty cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_r    <= {PW{1'b0}};
      rp_r    <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      wp_r    <= wp_r + PW'(enq_cnt_s);
      rp_r    <= rp_r + PW'(pop_s);
      count_r <= count_r + CW'(enq_cnt_s) - CW'(pop_s);
    end
  end

  // Entry storage; occupancy qualifies every read, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (mem_keep_s) begin
      addr_mem_r[wp_r] <= bus.mem_addr;
      data_mem_r[wp_r] <= bus.mem_data;
    end
    if (alu_keep_s) begin
      addr_mem_r[alu_slot_s] <= bus.alu_addr;
      data_mem_r[alu_slot_s] <= bus.alu_data;
    end
  end

  // Forwarding scan from oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = 32'd0;
    fwd_idx_s  = rp_r;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s = rp_r + PW'(i);
      if ((CW'(i) < count_r) && (bus.fwd_addr != 5'd0) &&
          (addr_mem_r[fwd_idx_s] == bus.fwd_addr)) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = data_mem_r[fwd_idx_s];
      end else begin
        fwd_hit_s  = fwd_hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  assign bus.mem_ready = mem_ready_s;
  assign bus.alu_ready = alu_ready_s;
  assign bus.reg_write = pop_s;
  assign bus.addr3     = pop_s ? addr_mem_r[rp_r] : 5'd0;
  assign bus.wdata     = pop_s ? data_mem_r[rp_r] : 32'd0;
  assign bus.fwd_hit   = fwd_hit_s;
  assign bus.fwd_data  = fwd_data_s;
  assign bus.count     = count_r;
  assign bus.empty     = !pop_s;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  ent_t mq[$];

  always #5 clk = ~clk;

  regfile_wb_queue_if #(.CW(CW)) bus ();

  regfile_wb_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_addr  = 5'd0;
    bus.alu_data  = 32'd0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = 5'd0;
    bus.mem_data  = 32'd0;
    bus.fwd_addr  = 5'd0;
  endtask

  // Advance one clock; the model applies the queue rules to the inputs seen at the edge.
  task automatic tick();
    int sz;
    bit macc, aacc;
    @(posedge clk);
    if (reset) begin
      mq.delete();
    end else begin
      sz   = mq.size();
      macc = bus.mem_valid && (sz <= DEPTH - 1);
      aacc = bus.alu_valid && (bus.mem_valid ? (sz <= DEPTH - 2) : (sz <= DEPTH - 1));
      if (sz > 0) void'(mq.pop_front());
      if (macc && bus.mem_addr != 5'd0) mq.push_back(ent_t'({bus.mem_addr, bus.mem_data}));
      if (aacc && bus.alu_addr != 5'd0) mq.push_back(ent_t'({bus.alu_addr, bus.alu_data}));
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd1;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd2;
    #1;
    total_cnt++; if (bus.mem_ready !== 1'b0) $display("FAIL reset_mem_ready: got %b want 0", bus.mem_ready); else pass_cnt++;
    total_cnt++; if (bus.alu_ready !== 1'b0) $display("FAIL reset_alu_ready: got %b want 0", bus.alu_ready); else pass_cnt++;
    tick();
    tick();
    reset = 1'b0;
    idle();
    bus.fwd_addr = 5'd1;
    #1;
    total_cnt++; if (bus.count !== 3'd0) $display("FAIL reset_count: got %0d want 0", bus.count); else pass_cnt++;
    total_cnt++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.empty); else pass_cnt++;
    total_cnt++; if (bus.reg_write !== 1'b0) $display("FAIL reset_reg_write: got %b want 0", bus.reg_write); else pass_cnt++;
    total_cnt++; if (bus.addr3 !== 5'd0 || bus.wdata !== 32'd0) $display("FAIL reset_wport: got %0d/%0d want 0/0", bus.addr3, bus.wdata); else pass_cnt++;
    total_cnt++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'd0) $display("FAIL reset_fwd: got %b/%0d want 0/0", bus.fwd_hit, bus.fwd_data); else pass_cnt++;
  endtask

  task automatic test_single_write();
    idle();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'd100;
    #1;
    total_cnt++; if (bus.alu_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", bus.alu_ready); else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++; if (bus.reg_write !== 1'b1 || bus.addr3 !== 5'd5 || bus.wdata !== 32'd100)
      $display("FAIL single_retire: got we=%b a=%0d d=%0d want 1/5/100", bus.reg_write, bus.addr3, bus.wdata); else pass_cnt++;
    total_cnt++; if (bus.count !== 3'd1) $display("FAIL single_count: got %0d want 1", bus.count); else pass_cnt++;
    tick();
    total_cnt++; if (bus.reg_write !== 1'b0 || bus.empty !== 1'b1 || bus.count !== 3'd0)
      $display("FAIL single_drain: got we=%b empty=%b count=%0d want 0/1/0", bus.reg_write, bus.empty, bus.count); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    idle();
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd3; bus.mem_data = 32'd7;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'd9;
    #1;
    total_cnt++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1)
      $display("FAIL simul_ready: got mem=%b alu=%b want 1/1", bus.mem_ready, bus.alu_ready); else pass_cnt++;
    tick();
    idle();
    bus.fwd_addr = 5'd3;
    #1;
    total_cnt++; if (bus.addr3 !== 5'd3 || bus.wdata !== 32'd7 || bus.count !== 3'd2)
      $display("FAIL simul_first: got a=%0d d=%0d c=%0d want 3/7/2", bus.addr3, bus.wdata, bus.count); else pass_cnt++;
    total_cnt++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'd9)
      $display("FAIL simul_fwd1: got %b/%0d want 1/9", bus.fwd_hit, bus.fwd_data); else pass_cnt++;
    tick();
    total_cnt++; if (bus.reg_write !== 1'b1 || bus.addr3 !== 5'd3 || bus.wdata !== 32'd9)
      $display("FAIL simul_second: got we=%b a=%0d d=%0d want 1/3/9", bus.reg_write, bus.addr3, bus.wdata); else pass_cnt++;
    total_cnt++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'd9)
      $display("FAIL simul_fwd2: got %b/%0d want 1/9", bus.fwd_hit, bus.fwd_data); else pass_cnt++;
    tick();
    total_cnt++; if (bus.reg_write !== 1'b0 || bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'd0)
      $display("FAIL simul_done: got we=%b hit=%b d=%0d want 0/0/0", bus.reg_write, bus.fwd_hit, bus.fwd_data); else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    idle();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'hFFFF_FFFF;
    #1;
    total_cnt++; if (bus.alu_ready !== 1'b1) $display("FAIL zero_ready: got %b want 1", bus.alu_ready); else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++; if (bus.count !== 3'd0 || bus.reg_write !== 1'b0)
      $display("FAIL zero_discard: got c=%0d we=%b want 0/0", bus.count, bus.reg_write); else pass_cnt++;
    total_cnt++; if (bus.fwd_hit !== 1'b0) $display("FAIL zero_fwd: got %b want 0", bus.fwd_hit); else pass_cnt++;
  endtask

  // Per-cycle comparison of every output against the model; optional random valids.
  task automatic test_backpressure(input int cycles, input bit rnd);
    int sz;
    bit eh;
    logic [31:0] ed;
    for (int c = 0; c < cycles; c++) begin
      idle();
      bus.mem_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.alu_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.mem_addr  = 5'($urandom_range(1, 31));
      bus.alu_addr  = 5'((bus.mem_addr % 31) + 1);
      if (rnd && $urandom_range(0, 5) == 0) bus.mem_addr = 5'd0;
      if (rnd && $urandom_range(0, 5) == 0) bus.alu_addr = 5'd0;
      bus.mem_data  = $urandom;
      bus.alu_data  = $urandom;
      sz = mq.size();
      if (sz > 0 && $urandom_range(0, 1) == 1) bus.fwd_addr = mq[$urandom_range(0, sz - 1)].a;
      else bus.fwd_addr = 5'($urandom_range(0, 31));
      eh = 1'b0; ed = 32'd0;
      foreach (mq[i]) if (bus.fwd_addr != 5'd0 && mq[i].a == bus.fwd_addr) begin eh = 1'b1; ed = mq[i].d; end
      #1;
      total_cnt++; if (bus.mem_ready !== (sz <= DEPTH - 1)) $display("FAIL bp_mem_ready: cyc %0d got %b want %b", c, bus.mem_ready, sz <= DEPTH - 1); else pass_cnt++;
      total_cnt++; if (bus.alu_ready !== (bus.mem_valid ? (sz <= DEPTH - 2) : (sz <= DEPTH - 1)))
        $display("FAIL bp_alu_ready: cyc %0d got %b count %0d", c, bus.alu_ready, sz); else pass_cnt++;
      total_cnt++; if (bus.count !== 3'(sz) || sz > DEPTH) $display("FAIL bp_count: cyc %0d got %0d want %0d", c, bus.count, sz); else pass_cnt++;
      total_cnt++; if (bus.reg_write !== (sz > 0) || (sz > 0 && (bus.addr3 !== mq[0].a || bus.wdata !== mq[0].d)))
        $display("FAIL bp_retire: cyc %0d got we=%b a=%0d d=%h want head of %0d", c, bus.reg_write, bus.addr3, bus.wdata, sz); else pass_cnt++;
      total_cnt++; if (bus.fwd_hit !== eh || bus.fwd_data !== ed)
        $display("FAIL bp_fwd: cyc %0d addr %0d got %b/%h want %b/%h", c, bus.fwd_addr, bus.fwd_hit, bus.fwd_data, eh, ed); else pass_cnt++;
      tick();
    end
    idle();
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_wrap();
    ent_t obs[$];
    for (int k = 1; k <= 10; k++) begin
      idle();
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        tick();
        if (bus.reg_write) obs.push_back(ent_t'({bus.addr3, bus.wdata}));
      end
      bus.alu_valid = 1'b1; bus.alu_addr = 5'(k); bus.alu_data = 32'(2 * k);
      tick();
      if (bus.reg_write) obs.push_back(ent_t'({bus.addr3, bus.wdata}));
    end
    idle();
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.reg_write) obs.push_back(ent_t'({bus.addr3, bus.wdata}));
    end
    total_cnt++; if (obs.size() != 10) $display("FAIL wrap_len: got %0d want 10", obs.size()); else pass_cnt++;
    for (int k = 1; k <= 10; k++) begin
      total_cnt++;
      if (k > obs.size() || obs[k-1].a !== 5'(k) || obs[k-1].d !== 32'(2 * k))
        $display("FAIL wrap_seq: entry %0d got %0d/%0d want %0d/%0d", k, (k > obs.size()) ? 0 : obs[k-1].a, (k > obs.size()) ? 0 : obs[k-1].d, k, 2 * k);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    idle();
    for (int c = 0; c < 4; c++) tick();
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd20; bus.mem_data = 32'd200;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd21; bus.alu_data = 32'd210;
    tick();
    bus.mem_addr = 5'd22; bus.mem_data = 32'd220;
    bus.alu_addr = 5'd23; bus.alu_data = 32'd230;
    tick();
    idle();
    #1;
    total_cnt++; if (bus.count !== 3'd3) $display("FAIL midrst_fill: got %0d want 3", bus.count); else pass_cnt++;
    reset = 1'b1;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd24;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd25;
    #1;
    total_cnt++; if (bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b0)
      $display("FAIL midrst_ready: got mem=%b alu=%b want 0/0", bus.mem_ready, bus.alu_ready); else pass_cnt++;
    tick();
    reset = 1'b0;
    idle();
    #1;
    total_cnt++; if (bus.count !== 3'd0 || bus.reg_write !== 1'b0)
      $display("FAIL midrst_clear: got c=%0d we=%b want 0/0", bus.count, bus.reg_write); else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      tick();
      total_cnt++;
      if (bus.reg_write !== 1'b0 || (bus.addr3 >= 5'd20 && bus.addr3 <= 5'd25))
        $display("FAIL midrst_leak: cyc %0d got we=%b a=%0d want 0/none", c, bus.reg_write, bus.addr3);
      else pass_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_zero_reg();
    test_backpressure(30, 1'b0);
    test_backpressure(60, 1'b1);
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
